// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM protection front-end.
// Channel count, defaults, filtered-input bundle and pad-index map.
package pwm_pkg;

  localparam int NCH_DEF      = 4;
  localparam int PWM_PERIOD   = 256;
  localparam int FILT_LEN_DEF = 4;
  localparam int MAX_LIM_DEF  = 4;

  // Pad block base and per-channel stride used by the pad wrapper.
  localparam int PAD_BASE   = 8;
  localparam int PAD_STRIDE = 4;

  typedef enum logic [1:0] {
    PAD_ILIM  = 2'd0,
    PAD_VLIM  = 2'd1,
    PAD_FAULT = 2'd2,
    PAD_FDET  = 2'd3
  } pad_kind_e;

  typedef struct packed {
    logic ilim;
    logic vlim;
    logic fault;
  } prot_in_t;

  function automatic logic [5:0] pad_idx(
    input logic [1:0] ch,
    input pad_kind_e  kind
  );
    pad_idx = 6'(PAD_BASE)
            + 6'({ch, 2'b00})
            + 6'(kind);
  endfunction

endpackage

// File: rtl/prot_glitch_filter.sv
// Two-FF synchroniser plus persistence filter for one pad bit.
// Ports: clk_i, rst_ni (async low), d_i raw pad, q_o filtered level.
module prot_glitch_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

  logic          s1_q, s2_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Level moves only after FILT_LEN consecutive disagreeing samples.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (s2_q != filt_q) begin
      if (cnt_q == LAST) begin
        filt_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign q_o = filt_q;

endmodule

// File: rtl/pwm_protect_conditioner.sv
// Protection front-end: filtered limits -> per-period hi-side kill,
// escalation and fault pads -> latched channel disable / FAULT_DETECT.
module pwm_protect_conditioner
  import pwm_pkg::*;
#(
  parameter int NCH      = NCH_DEF,
  parameter int FILT_LEN = FILT_LEN_DEF,
  parameter int MAX_LIM  = MAX_LIM_DEF,
  parameter int CNT_W    = $clog2(MAX_LIM) + 1
) (
  input  logic           wb_clk_i,
  input  logic           resetb,
  input  logic [NCH-1:0] i_limit_in,
  input  logic [NCH-1:0] v_limit_in,
  input  logic [NCH-1:0] fault_in,
  input  logic [NCH-1:0] cycle,
  input  logic [NCH-1:0] fault_clear,
  output logic [NCH-1:0] hi_kill,
  output logic [NCH-1:0] ch_disable,
  output logic [NCH-1:0] fault_detect
);

  localparam logic [CNT_W-1:0] ESC_MAX = CNT_W'(MAX_LIM);
  localparam logic [CNT_W-1:0] ESC_PRE = CNT_W'(MAX_LIM - 1);

  for (genvar c = 0; c < NCH; c++) begin : g_ch

    prot_in_t filt;

    prot_glitch_filter #(.FILT_LEN(FILT_LEN)) u_ilim (
      .clk_i  (wb_clk_i),
      .rst_ni (resetb),
      .d_i    (i_limit_in[c]),
      .q_o    (filt.ilim)
    );

    prot_glitch_filter #(.FILT_LEN(FILT_LEN)) u_vlim (
      .clk_i  (wb_clk_i),
      .rst_ni (resetb),
      .d_i    (v_limit_in[c]),
      .q_o    (filt.vlim)
    );

    prot_glitch_filter #(.FILT_LEN(FILT_LEN)) u_flt (
      .clk_i  (wb_clk_i),
      .rst_ni (resetb),
      .d_i    (fault_in[c]),
      .q_o    (filt.fault)
    );

    logic             lim_q, lim_d;
    logic             seen_q, seen_d;
    logic             flt_q, flt_d;
    logic [CNT_W-1:0] esc_q, esc_d;
    logic             lim_act, hit;
    logic             esc_set, flt_set, flt_clr;

    always_comb begin
      lim_act = filt.ilim | filt.vlim;
      // A limit this very edge still counts for the closing period.
      hit     = seen_q | lim_act;
      esc_set = cycle[c] & hit & (esc_q == ESC_PRE);
      flt_set = filt.fault | esc_set;
      flt_clr = fault_clear[c] & flt_q & ~flt_set;

      lim_d  = lim_act | (lim_q & ~cycle[c]);
      seen_d = cycle[c] ? lim_act : (seen_q | lim_act);

      esc_d = esc_q;
      if (cycle[c]) begin
        if (!hit) begin
          esc_d = '0;
        end else if (esc_q != ESC_MAX) begin
          esc_d = esc_q + 1'b1;
        end
      end
      if (flt_clr) begin
        esc_d = '0;
      end

      flt_d = flt_set | (flt_q & ~flt_clr);
    end

    always_ff @(posedge wb_clk_i or negedge resetb) begin
      if (!resetb) begin
        lim_q  <= 1'b0;
        seen_q <= 1'b0;
        flt_q  <= 1'b0;
        esc_q  <= '0;
      end else begin
        lim_q  <= lim_d;
        seen_q <= seen_d;
        flt_q  <= flt_d;
        esc_q  <= esc_d;
      end
    end

    assign hi_kill[c]      = lim_q | flt_q;
    assign ch_disable[c]   = flt_q;
    assign fault_detect[c] = flt_q;

  end

endmodule

// File: tb/tb_pwm_protect_conditioner.sv
// Directed bench for pwm_protect_conditioner.
// Glitch, limit, escalation, fault/clear, overlap and reset steps.
`timescale 1ns/1ps
module tb_pwm_protect_conditioner;

  logic       clk;
  logic       resetb;
  logic [3:0] i_lim, v_lim, flt_in, cyc, clr;
  logic [3:0] hi_kill, ch_dis, fdet;

  int checks = 0;
  int errors = 0;

  pwm_protect_conditioner dut (
    .wb_clk_i     (clk),
    .resetb       (resetb),
    .i_limit_in   (i_lim),
    .v_limit_in   (v_lim),
    .fault_in     (flt_in),
    .cycle        (cyc),
    .fault_clear  (clr),
    .hi_kill      (hi_kill),
    .ch_disable   (ch_dis),
    .fault_detect (fdet)
  );

  initial begin
    clk = 1'b0;
    forever #12.5 clk = ~clk;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic pulse_cycle(input logic [3:0] m,
                             input logic [3:0] c);
    cyc = m;
    clr = c;
    step(1);
    cyc = 4'h0;
    clr = 4'h0;
  endtask

  // One 256-clk period on ch2, optionally with a 6-clk v_limit pulse.
  task automatic ch2_period(input bit act, input bit do_clr);
    v_lim[2] = act;
    step(6);
    v_lim[2] = 1'b0;
    step(249);
    pulse_cycle(4'b0100, do_clr ? 4'b0100 : 4'b0000);
  endtask

  initial begin
    resetb = 1'b1;
    i_lim  = 4'h0;
    v_lim  = 4'h0;
    flt_in = 4'h0;
    cyc    = 4'h0;
    clr    = 4'h0;
    #3 resetb = 1'b0;
    #1;
    chk("rst_hi_kill", hi_kill, 4'h0);
    chk("rst_ch_dis", ch_dis, 4'h0);
    chk("rst_fdet", fdet, 4'h0);
    step(3);
    resetb = 1'b1;
    step(3);
    chk("idle_hi_kill", hi_kill, 4'h0);

    // Glitch filter on ch0
    i_lim[0] = 1'b1;
    step(3);
    i_lim[0] = 1'b0;
    step(10);
    chk("glitch3", hi_kill, 4'h0);
    i_lim[0] = 1'b1;
    step(4);
    i_lim[0] = 1'b0;
    step(2);
    chk("pulse4_e6", hi_kill, 4'h0);
    step(1);
    chk("pulse4_e7", hi_kill, 4'b0001);
    step(10);
    chk("lim0_hold", hi_kill, 4'b0001);
    pulse_cycle(4'b0001, 4'h0);
    chk("lim0_cyc_clr", hi_kill, 4'h0);

    // Limit on ch1 for 10 clks
    i_lim[1] = 1'b1;
    step(6);
    chk("lim1_e6", hi_kill, 4'h0);
    step(1);
    chk("lim1_e7", hi_kill, 4'b0010);
    step(3);
    i_lim[1] = 1'b0;
    step(1);
    pulse_cycle(4'b0010, 4'h0);
    chk("lim1_cyc_active", hi_kill, 4'b0010);
    step(10);
    chk("lim1_after_rel", hi_kill, 4'b0010);
    pulse_cycle(4'b0010, 4'h0);
    chk("lim1_cleared", hi_kill, 4'h0);
    chk("lim1_no_fdet", fdet, 4'h0);

    // Escalation on ch2
    ch2_period(1'b1, 1'b0);
    ch2_period(1'b1, 1'b0);
    ch2_period(1'b1, 1'b0);
    chk("esc_3rd", ch_dis, 4'h0);
    ch2_period(1'b1, 1'b0);
    chk("esc_4th_dis", ch_dis, 4'b0100);
    chk("esc_4th_fdet", fdet, 4'b0100);
    chk("esc_4th_kill", hi_kill, 4'b0100);
    step(3);
    pulse_cycle(4'h0, 4'b0100);
    chk("esc_cleared", ch_dis, 4'h0);
    ch2_period(1'b1, 1'b0);
    ch2_period(1'b1, 1'b0);
    ch2_period(1'b1, 1'b0);
    ch2_period(1'b0, 1'b0);
    chk("esc_clean_gap", ch_dis, 4'h0);
    ch2_period(1'b1, 1'b0);
    ch2_period(1'b1, 1'b0);
    ch2_period(1'b1, 1'b0);
    chk("esc_pre_set", ch_dis, 4'h0);
    ch2_period(1'b1, 1'b1);
    chk("esc_vs_clear", ch_dis, 4'b0100);
    pulse_cycle(4'h0, 4'b0100);
    chk("esc_clear2", ch_dis, 4'h0);

    // Fault pad and software clear on ch3
    flt_in[3] = 1'b1;
    step(6);
    chk("flt3_e6", ch_dis, 4'h0);
    step(1);
    chk("flt3_e7", ch_dis, 4'b1000);
    chk("flt3_fdet", fdet, 4'b1000);
    chk("flt3_kill", hi_kill, 4'b1000);
    pulse_cycle(4'h0, 4'b1000);
    chk("flt3_clr_ignored", ch_dis, 4'b1000);
    flt_in[3] = 1'b0;
    step(8);
    chk("flt3_latched", ch_dis, 4'b1000);
    pulse_cycle(4'h0, 4'b1000);
    chk("flt3_cleared", ch_dis, 4'h0);
    chk("flt3_kill_off", hi_kill, 4'h0);

    // Filtered limit active on the cycle edge keeps lim set
    i_lim[0] = 1'b1;
    step(7);
    chk("sim_lim_on", hi_kill, 4'b0001);
    pulse_cycle(4'b0001, 4'h0);
    chk("sim_lim_held", hi_kill, 4'b0001);
    i_lim[0] = 1'b0;
    step(8);
    pulse_cycle(4'b0001, 4'h0);
    chk("sim_lim_rel", hi_kill, 4'h0);
    chk("sim_no_flt", ch_dis, 4'h0);

    // Async reset while all channels faulted
    flt_in = 4'hF;
    step(7);
    chk("all_flt", ch_dis, 4'hF);
    #5;
    resetb = 1'b0;
    flt_in = 4'h0;
    #1;
    chk("arst_kill", hi_kill, 4'h0);
    chk("arst_dis", ch_dis, 4'h0);
    chk("arst_fdet", fdet, 4'h0);
    step(2);
    resetb = 1'b1;
    step(2);
    flt_in[0] = 1'b1;
    step(7);
    chk("post_rst_dis", ch_dis, 4'b0001);
    chk("post_rst_kill", hi_kill, 4'b0001);
    flt_in[0] = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
